fifo_rd_sched: RTL



---
 rtl/fifo_rd_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fifo_rd_sched.sv
// Round-robin burst read scheduler sharing one sink between NCH sample FIFOs.
// Define FIFO_RD_SCHED_STRICT_PRI_EN for fixed lowest-index-first arbitration.
module fifo_rd_sched #(
    parameter int NCH       = 2,
    parameter int BURST_LEN = 16,
    parameter int CH_WID    = (NCH > 2) ? $clog2(NCH) : 1,
    parameter int CNT_WID   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic [NCH-1:0]    rempty,
    input  logic              dst_ready,
    output logic [NCH-1:0]    rinc,
    output logic [CH_WID-1:0] grant_ch,
    output logic              busy,
    output logic              data_vld,
    output logic [CH_WID-1:0] data_ch,
    output logic              burst_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CH_WID-1:0]   grant_ch_r;
    logic [CH_WID-1:0]   last_grant_r;
    logic [CH_WID-1:0]   pick_s;
    logic [CNT_WID-1:0]  beat_cnt_r;
    logic                pop_s;
    logic [NCH-1:0]      rinc_s;
    logic                data_vld_r;
    logic [CH_WID-1:0]   data_ch_r;
    logic                burst_done_r;

    // Arbitration scan; the first non-empty channel in scan order wins.
    function automatic logic [CH_WID-1:0] arb_pick(input logic [NCH-1:0] empty,
                                                   input logic [CH_WID-1:0] last);
        logic [CH_WID-1:0] sel;
        logic              found;
        int                idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
`ifdef FIFO_RD_SCHED_STRICT_PRI_EN
            idx = k + (int'(last) & 0);
`else
            idx = (int'(last) + k + 1) % NCH;
`endif
            sel   = (!found && !empty[idx]) ? CH_WID'(idx) : sel;
            found = found | ~empty[idx];
        end
        return sel;
    endfunction

    assign pick_s = arb_pick(rempty, last_grant_r);

    // Next-state and pop strobe; a dry or disabled channel exits without popping.
    always_comb begin
        state_s = state_r;
        rinc_s  = '0;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && !(&rempty)) begin
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                pop_s              = enable & dst_ready & ~rempty[grant_ch_r];
                rinc_s[grant_ch_r] = pop_s;
                if (!enable || rempty[grant_ch_r]) begin
                    state_s = GAP;
                end else if (pop_s && (beat_cnt_r == CNT_WID'(BURST_LEN - 1))) begin
                    state_s = GAP;
                end else begin
                    state_s = BURST;
                end
            end
            GAP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant capture, beat counting and round-robin history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_ch_r   <= '0;
            beat_cnt_r   <= '0;
            last_grant_r <= CH_WID'(NCH - 1);
        end else begin
            if (state_r == IDLE && state_s == BURST) begin
                grant_ch_r <= pick_s;
                beat_cnt_r <= '0;
            end else if (pop_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_WID'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (state_r == GAP) begin
                last_grant_r <= grant_ch_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Read-data tag stream trails the pop by the one-cycle RAM latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_vld_r   <= 1'b0;
            data_ch_r    <= '0;
            burst_done_r <= 1'b0;
        end else begin
            data_vld_r   <= pop_s;
            data_ch_r    <= pop_s ? grant_ch_r : data_ch_r;
            burst_done_r <= (state_s == GAP);
        end
    end

    assign rinc       = rinc_s;
    assign grant_ch   = grant_ch_r;
    assign busy       = (state_r == BURST);
    assign data_vld   = data_vld_r;
    assign data_ch    = data_ch_r;
    assign burst_done = burst_done_r;

endmodule
